// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } stretch_state_t;

  // Elaboration-time max, used to size the shared ON/GAP tick counter.
  function automatic int cmax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stretch_tick_gen.sv
// Free-running divider producing a one-cycle tick every SAMPLE_CNT_MAX clocks.
module stretch_tick_gen #(
  parameter int SAMPLE_CNT_MAX = 62500
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  // At least one bit so a divide-by-one build still has a legal counter.
  localparam int CW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_CNT_MAX - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  // Count 0..SAMPLE_CNT_MAX-1 and wrap on the tick cycle.
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else if (tick) count <= '0;
    else count <= count + 1'b1;
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into visible ON intervals followed by a
// mandatory dark GAP; events arriving while busy are queued in a saturating
// per-channel pending counter.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int ON_CNT_MAX     = 100,
  parameter int GAP_CNT_MAX    = 50,
  parameter int PENDING_MAX    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] busy
);

  localparam int CNT_W  = $clog2(cmax(ON_CNT_MAX, GAP_CNT_MAX) + 1);
  localparam int PEND_W = $clog2(PENDING_MAX + 1);
  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CNT_MAX - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_CNT_MAX - 1);
  localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PENDING_MAX);

  logic tick;

  stretch_tick_gen #(
    .SAMPLE_CNT_MAX(SAMPLE_CNT_MAX)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    stretch_state_t    state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [PEND_W-1:0] pend, pend_n;
    logic              out_q, busy_q;
    logic              ev;

    assign ev = in[i];

    // Next-state logic: ON/GAP timing, GAP-exit arbitration and pending queue.
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pend_n  = pend;
      case (state)
        IDLE: begin
          if (ev) begin
            state_n = ON;
            cnt_n   = '0;
          end
        end
        ON: begin
          if (tick) begin
            if (cnt == ON_LAST) begin
              state_n = GAP;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          if (ev && pend != PEND_TOP) pend_n = pend + 1'b1;
        end
        GAP: begin
          if (tick && cnt == GAP_LAST) begin
            cnt_n = '0;
            if (pend != '0) begin
              // A simultaneous new event replaces the one being consumed.
              state_n = ON;
              if (!ev) pend_n = pend - 1'b1;
            end else if (ev) begin
              state_n = ON;
            end else begin
              state_n = IDLE;
            end
          end else begin
            if (tick) cnt_n = cnt + 1'b1;
            if (ev && pend != PEND_TOP) pend_n = pend + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          pend_n  = '0;
        end
      endcase
    end

    // State registers; outputs are registered from the next-state values.
    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        cnt    <= '0;
        pend   <= '0;
        out_q  <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        state  <= state_n;
        cnt    <= cnt_n;
        pend   <= pend_n;
        out_q  <= (state_n == ON);
        busy_q <= (state_n != IDLE) || (pend_n != '0);
      end
    end

    assign out[i]  = out_q;
    assign busy[i] = busy_q;
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed scenarios with hand-derived ON/busy windows; stimulus pushes the
// expected outputs per cycle and a negedge monitor pops and compares.
module tb_pulse_stretcher;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in  = '0;
  logic [W-1:0] out, busy;

  pulse_stretcher #(
    .WIDTH(W), .SAMPLE_CNT_MAX(4), .ON_CNT_MAX(3), .GAP_CNT_MAX(2), .PENDING_MAX(3)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] busy;
    int           cyc;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string cur_name;

  // Scenario description (cycle 0 = first cycle after reset release)
  int p0[$], p1[$];
  int on0_s[$], on0_e[$], on1_s[$], on1_e[$];
  int b0_s, b0_e, b1_s, b1_e;   // busy high for b_s <= c < b_e
  int rst_cyc;

  function automatic bit member(input int q[$], input int c);
    foreach (q[k]) if (q[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit in_iv(input int s[$], input int e[$], input int c);
    foreach (s[k]) if (c >= s[k] && c <= e[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic exp_t expect_at(input int c);
    exp_t x;
    x.cyc  = c;
    x.out  = '0;
    x.busy = '0;
    if (rst_cyc < 0 || c <= rst_cyc) begin
      x.out[0]  = in_iv(on0_s, on0_e, c);
      x.out[1]  = in_iv(on1_s, on1_e, c);
      x.busy[0] = (c >= b0_s && c < b0_e);
      x.busy[1] = (c >= b1_s && c < b1_e);
    end
    return x;
  endfunction

  task automatic clear_scn();
    p0.delete(); p1.delete();
    on0_s.delete(); on0_e.delete(); on1_s.delete(); on1_e.delete();
    b0_s = -1; b0_e = -1; b1_s = -1; b1_e = -1;
    rst_cyc = -1;
  endtask

  task automatic run(input string name, input int ncyc);
    exp_t r;
    cur_name = name;
    rst = 1'b1;
    in  = '0;
    @(posedge clk); #1;
    r.out = '0; r.busy = '0; r.cyc = -1;
    exp_q.push_back(r);                 // reset state
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      in[0] = member(p0, c);
      in[1] = member(p1, c);
      rst   = (c == rst_cyc);
      exp_q.push_back(expect_at(c));
      @(posedge clk); #1;
    end
    in  = '0;
    rst = 1'b0;
  endtask

  // Monitor: compare every registered output sample against the scoreboard.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (out !== e.out || busy !== e.busy) begin
        errors++;
        $display("FAIL %s cycle %0d: out=%b busy=%b, expected out=%b busy=%b",
                 cur_name, e.cyc, out, busy, e.out, e.busy);
      end
    end
  end

  initial begin
    clear_scn();
    p0 = '{0};
    on0_s = '{1}; on0_e = '{11}; b0_s = 1; b0_e = 20;
    run("single", 30);

    clear_scn();
    p0 = '{0, 5};
    on0_s = '{1, 20}; on0_e = '{11, 31}; b0_s = 1; b0_e = 40;
    run("queued", 50);

    clear_scn();
    p0 = '{0, 2, 4, 6, 8};
    on0_s = '{1, 20, 40, 60}; on0_e = '{11, 31, 51, 71}; b0_s = 1; b0_e = 80;
    run("saturate", 90);

    clear_scn();
    p0 = '{0, 19};
    on0_s = '{1, 20}; on0_e = '{11, 31}; b0_s = 1; b0_e = 40;
    run("exit_and_event", 50);

    clear_scn();
    p0 = '{0, 3};
    rst_cyc = 6;
    on0_s = '{1}; on0_e = '{6}; b0_s = 1; b0_e = 1000;
    run("reset_mid_on", 40);

    clear_scn();
    p0 = '{0}; p1 = '{9};
    on0_s = '{1};  on0_e = '{11}; b0_s = 1;  b0_e = 20;
    on1_s = '{10}; on1_e = '{19}; b1_s = 10; b1_e = 28;
    run("independent", 40);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d samples left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
